// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator CPU control path.
//   opcode_t : 5-bit instruction opcodes
//   state_t  : control sequencer states
//   ctl_t    : datapath control bundle produced by the decoder
package cpu_pkg;

  localparam int unsigned OPERAND_WIDTH = 11;
  localparam int unsigned DATA_WIDTH    = 16;
  localparam int unsigned OPCODE_WIDTH  = DATA_WIDTH - OPERAND_WIDTH;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_HLT  = 5'd0,
    OP_STO  = 5'd1,
    OP_LD   = 5'd2,
    OP_LDI  = 5'd3,
    OP_ADD  = 5'd4,
    OP_ADDI = 5'd5,
    OP_SUB  = 5'd6,
    OP_SUBI = 5'd7,
    OP_BEQ  = 5'd8,
    OP_BNE  = 5'd9,
    OP_BGT  = 5'd10,
    OP_BGE  = 5'd11,
    OP_BLT  = 5'd12,
    OP_BLE  = 5'd13,
    OP_JMP  = 5'd14
  } opcode_t;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [1:0] SEL_A_MEM = 2'b00;
  localparam logic [1:0] SEL_A_IMM = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef struct packed {
    logic       acc_wr;
    logic       status_wr;
    logic       data_wr;
    logic       illegal;
    logic       alu_op;
    logic [1:0] sel_a;
    logic       sel_b;
  } ctl_t;

  // Conditional branch predicate from the datapath zero/negative flags.
  function automatic logic branch_taken(input opcode_t op, input logic z, input logic n);
    case (op)
      OP_BEQ:  return z;
      OP_BNE:  return !z;
      OP_BGT:  return !z && !n;
      OP_BGE:  return !n;
      OP_BLT:  return n;
      OP_BLE:  return n || z;
      OP_JMP:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational decode of (state, opcode, flags) into datapath controls and sequencing.
//   state/opcode  : registered sequencer state and IR opcode field
//   z/n           : datapath status flags (used only for branch resolution)
//   valid/run     : fetch handshake and halt-release level
//   next_state    : sequencer next state
//   ir_load       : capture instruction and advance PC
//   pc_load       : load PC from operand (taken branch / jump)
//   ctl           : datapath strobes and selects
//   req/halted    : fetch request and halt indicator
module control_decoder
  import cpu_pkg::*;
(
  input  state_t  state,
  input  opcode_t opcode,
  input  logic    z,
  input  logic    n,
  input  logic    valid,
  input  logic    run,
  output state_t  next_state,
  output logic    ir_load,
  output logic    pc_load,
  output ctl_t    ctl,
  output logic    req,
  output logic    halted
);

  always_comb begin
    next_state = ST_FETCH;
    ir_load    = 1'b0;
    pc_load    = 1'b0;
    ctl        = '0;
    req        = 1'b0;
    halted     = 1'b0;

    case (state)
      ST_FETCH: begin
        req = 1'b1;
        if (valid) begin
          ir_load    = 1'b1;
          next_state = ST_DECODE;
        end else begin
          next_state = ST_FETCH;
        end
      end

      ST_DECODE: begin
        next_state = (opcode == OP_HLT) ? ST_HALT : ST_EXEC;
      end

      ST_EXEC: begin
        case (opcode)
          OP_HLT: next_state = ST_HALT;
          OP_STO: ctl.data_wr = 1'b1;
          OP_LD:  next_state = ST_WB;
          OP_LDI: begin
            ctl.sel_a  = SEL_A_IMM;
            ctl.acc_wr = 1'b1;
          end
          OP_ADD, OP_SUB: next_state = ST_WB;
          OP_ADDI, OP_SUBI: begin
            ctl.sel_b     = 1'b1;
            ctl.sel_a     = SEL_A_ALU;
            ctl.alu_op    = (opcode == OP_SUBI) ? ALU_SUB : ALU_ADD;
            ctl.acc_wr    = 1'b1;
            ctl.status_wr = 1'b1;
          end
          OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE, OP_JMP:
            pc_load = branch_taken(opcode, z, n);
          default: ctl.illegal = 1'b1;
        endcase
      end

      // Second cycle for ops that wait on the synchronous data-memory read.
      ST_WB: begin
        case (opcode)
          OP_LD: begin
            ctl.sel_a  = SEL_A_MEM;
            ctl.acc_wr = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctl.sel_b     = 1'b0;
            ctl.sel_a     = SEL_A_ALU;
            ctl.alu_op    = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
            ctl.acc_wr    = 1'b1;
            ctl.status_wr = 1'b1;
          end
          default: ;
        endcase
      end

      ST_HALT: begin
        halted     = 1'b1;
        next_state = run ? ST_FETCH : ST_HALT;
      end

      default: next_state = ST_FETCH;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the accumulator datapath: fetch, decode, execute, write-back, halt.
//   clock_in/reset_in          : clock, synchronous active-high reset
//   run_in                     : releases HALT
//   instr_in/instr_valid_in    : instruction memory response
//   status_Z_in/status_N_in    : datapath flags for branches
//   instr_req_out/pc_out       : fetch request and instruction address
//   operand_out                : IR operand field to datapath
//   alu_op/sel_A/sel_B/acc_wr/status_wr/data_wr : datapath controls
//   acc_reset/status_reset     : reset passthrough to datapath registers
//   halted_out/illegal_out     : halt indicator, undefined-opcode pulse
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned PC_RESET = 0
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic                     run_in,
  input  logic [DATA_WIDTH-1:0]    instr_in,
  input  logic                     instr_valid_in,
  input  logic                     status_Z_in,
  input  logic                     status_N_in,
  output logic                     instr_req_out,
  output logic [OPERAND_WIDTH-1:0] pc_out,
  output logic [OPERAND_WIDTH-1:0] operand_out,
  output logic                     alu_op_out,
  output logic [1:0]               sel_A_out,
  output logic                     sel_B_out,
  output logic                     acc_wr_out,
  output logic                     status_wr_out,
  output logic                     acc_reset_out,
  output logic                     status_reset_out,
  output logic                     data_wr_out,
  output logic                     halted_out,
  output logic                     illegal_out
);

  state_t                   state;
  state_t                   next_state;
  logic [DATA_WIDTH-1:0]    ir;
  logic [OPERAND_WIDTH-1:0] pc;
  logic                     ir_load;
  logic                     pc_load;
  logic                     req;
  logic                     halted;
  ctl_t                     ctl;
  opcode_t                  opcode;

  assign opcode      = opcode_t'(ir[DATA_WIDTH-1:OPERAND_WIDTH]);
  assign operand_out = ir[OPERAND_WIDTH-1:0];
  assign pc_out      = pc;

  control_decoder u_decoder (
    .state      (state),
    .opcode     (opcode),
    .z          (status_Z_in),
    .n          (status_N_in),
    .valid      (instr_valid_in),
    .run        (run_in),
    .next_state (next_state),
    .ir_load    (ir_load),
    .pc_load    (pc_load),
    .ctl        (ctl),
    .req        (req),
    .halted     (halted)
  );

  // Sequencer state, instruction register and program counter.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state <= ST_FETCH;
      pc    <= OPERAND_WIDTH'(PC_RESET);
      ir    <= '0;
    end else begin
      state <= next_state;
      if (ir_load) begin
        ir <= instr_in;
        pc <= pc + OPERAND_WIDTH'(1);
      end else if (pc_load) begin
        pc <= ir[OPERAND_WIDTH-1:0];
      end
    end
  end

  // Reset aborts an in-flight instruction, so its strobes are suppressed in that cycle.
  assign acc_wr_out       = ctl.acc_wr    & ~reset_in;
  assign status_wr_out    = ctl.status_wr & ~reset_in;
  assign data_wr_out      = ctl.data_wr   & ~reset_in;
  assign illegal_out      = ctl.illegal   & ~reset_in;
  assign halted_out       = halted        & ~reset_in;
  assign instr_req_out    = req;
  assign alu_op_out       = ctl.alu_op;
  assign sel_A_out        = ctl.sel_a;
  assign sel_B_out        = ctl.sel_b;
  assign acc_reset_out    = reset_in;
  assign status_reset_out = reset_in;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios followed by random instruction streams,
// each instruction checked cycle by cycle against a table-driven instruction-level model.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic        run_in = 1'b0;
  logic [15:0] instr_in = '0;
  logic        instr_valid_in = 1'b0;
  logic        status_Z_in = 1'b0;
  logic        status_N_in = 1'b0;
  logic        instr_req_out;
  logic [10:0] pc_out;
  logic [10:0] operand_out;
  logic        alu_op_out;
  logic [1:0]  sel_A_out;
  logic        sel_B_out;
  logic        acc_wr_out;
  logic        status_wr_out;
  logic        acc_reset_out;
  logic        status_reset_out;
  logic        data_wr_out;
  logic        halted_out;
  logic        illegal_out;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [10:0] exp_pc;

  // Model tables indexed by opcode: control vector in EXEC / WB and whether WB exists.
  logic [9:0]  exec_exp [32];
  logic [9:0]  wb_exp   [32];
  bit          has_wb   [32];

  always #5 clk = ~clk;

  control_unit dut (
    .clock_in         (clk),
    .reset_in         (reset_in),
    .run_in           (run_in),
    .instr_in         (instr_in),
    .instr_valid_in   (instr_valid_in),
    .status_Z_in      (status_Z_in),
    .status_N_in      (status_N_in),
    .instr_req_out    (instr_req_out),
    .pc_out           (pc_out),
    .operand_out      (operand_out),
    .alu_op_out       (alu_op_out),
    .sel_A_out        (sel_A_out),
    .sel_B_out        (sel_B_out),
    .acc_wr_out       (acc_wr_out),
    .status_wr_out    (status_wr_out),
    .acc_reset_out    (acc_reset_out),
    .status_reset_out (status_reset_out),
    .data_wr_out      (data_wr_out),
    .halted_out       (halted_out),
    .illegal_out      (illegal_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {req, acc_wr, status_wr, data_wr, illegal, halted, alu_op, sel_A[1:0], sel_B}
  function automatic logic [9:0] mk(input logic req, input logic aw, input logic sw,
                                    input logic dw, input logic il, input logic ht,
                                    input logic alu, input logic [1:0] sa, input logic sb);
    return {req, aw, sw, dw, il, ht, alu, sa, sb};
  endfunction

  function automatic logic [9:0] obs_ctl();
    return {instr_req_out, acc_wr_out, status_wr_out, data_wr_out, illegal_out,
            halted_out, alu_op_out, sel_A_out, sel_B_out};
  endfunction

  function automatic bit taken(input int op, input logic z, input logic n);
    case (op)
      8:       return z;
      9:       return !z;
      10:      return !z && !n;
      11:      return !n;
      12:      return n;
      13:      return n || z;
      14:      return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic init_model();
    for (int op = 0; op < 32; op++) begin
      exec_exp[op] = '0;
      wb_exp[op]   = '0;
      has_wb[op]   = 1'b0;
      if (op >= 15) exec_exp[op] = mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 0);
    end
    exec_exp[1] = mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 0);
    exec_exp[3] = mk(0, 1, 0, 0, 0, 0, 0, 2'b01, 0);
    exec_exp[5] = mk(0, 1, 1, 0, 0, 0, 0, 2'b10, 1);
    exec_exp[7] = mk(0, 1, 1, 0, 0, 0, 1, 2'b10, 1);
    has_wb[2] = 1'b1;  wb_exp[2] = mk(0, 1, 0, 0, 0, 0, 0, 2'b00, 0);
    has_wb[4] = 1'b1;  wb_exp[4] = mk(0, 1, 1, 0, 0, 0, 0, 2'b10, 0);
    has_wb[6] = 1'b1;  wb_exp[6] = mk(0, 1, 1, 0, 0, 0, 1, 2'b10, 0);
  endtask

  // Issue one instruction from FETCH and check every cycle until the next FETCH.
  task automatic run_instr(input int op, input int operand, input logic z, input logic n,
                           input int wait_cyc, input string tag);
    logic [4:0]  op5;
    logic [10:0] opd;
    logic [10:0] pc_next;
    int          cyc;
    op5 = 5'(op);
    opd = 11'(operand);
    cyc = 0;
    for (int w = 0; w < wait_cyc; w++) begin
      chk({tag, ":stall_ctl"}, 32'(obs_ctl()), 32'(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0)));
      chk({tag, ":stall_pc"}, 32'(pc_out), 32'(exp_pc));
      instr_in = 16'($urandom);
      tick();
    end
    chk({tag, ":fetch_ctl"}, 32'(obs_ctl()), 32'(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0)));
    chk({tag, ":fetch_pc"}, 32'(pc_out), 32'(exp_pc));
    instr_in       = {op5, opd};
    instr_valid_in = 1'b1;
    tick(); cyc++;
    instr_valid_in = 1'b0;
    instr_in       = 16'($urandom);
    pc_next        = exp_pc + 11'd1;
    chk({tag, ":decode_ctl"}, 32'(obs_ctl()), 32'(0));
    chk({tag, ":decode_pc"}, 32'(pc_out), 32'(pc_next));
    chk({tag, ":operand"}, 32'(operand_out), 32'(opd));
    status_Z_in = z;
    status_N_in = n;
    tick(); cyc++;
    if (op == 0) begin
      exp_pc = pc_next;
      for (int h = 0; h < 10; h++) begin
        chk({tag, ":halt_ctl"}, 32'(obs_ctl()), 32'(mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 0)));
        chk({tag, ":halt_pc"}, 32'(pc_out), 32'(exp_pc));
        tick();
      end
      run_in = 1'b1;
      chk({tag, ":halt_run"}, 32'(halted_out), 32'(1));
      tick();
      run_in = 1'b0;
      return;
    end
    chk({tag, ":exec_ctl"}, 32'(obs_ctl()), 32'(exec_exp[op]));
    tick(); cyc++;
    if (has_wb[op]) begin
      chk({tag, ":wb_ctl"}, 32'(obs_ctl()), 32'(wb_exp[op]));
      tick(); cyc++;
    end
    chk({tag, ":latency"}, 32'(cyc), 32'(has_wb[op] ? 4 : 3));
    exp_pc = taken(op, z, n) ? opd : pc_next;
  endtask

  initial begin
    init_model();

    // Reset held two cycles.
    reset_in = 1'b1;
    tick();
    tick();
    chk("reset_ctl", 32'(obs_ctl()), 32'(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0)));
    chk("reset_pc", 32'(pc_out), 32'(0));
    chk("reset_operand", 32'(operand_out), 32'(0));
    chk("reset_pass", 32'({acc_reset_out, status_reset_out}), 32'(2'b11));
    reset_in = 1'b0;
    #1;
    chk("reset_pass_low", 32'({acc_reset_out, status_reset_out}), 32'(2'b00));
    exp_pc = 11'd0;

    run_instr(3, 5, 0, 0, 0, "ldi5");
    run_instr(3, 9, 0, 0, 4, "ldi_stall");
    run_instr(4, 3, 0, 0, 0, "add3");
    run_instr(6, 7, 0, 1, 1, "sub");
    run_instr(1, 12, 0, 0, 0, "sto");
    run_instr(2, 12, 0, 0, 0, "ld");
    run_instr(8, 32, 1, 0, 0, "beq_taken");
    run_instr(8, 32, 0, 0, 0, "beq_not");
    run_instr(13, 100, 0, 1, 0, "ble_n");
    run_instr(10, 200, 0, 1, 0, "bgt_not");
    run_instr(14, int'(exp_pc), 0, 0, 0, "jmp_self");
    run_instr(14, 2047, 0, 0, 0, "jmp_top");
    run_instr(3, 1, 0, 0, 0, "wrap");
    chk("wrap_pc", 32'(exp_pc), 32'(0));
    run_instr(31, 5, 0, 0, 0, "illegal31");
    run_instr(15, 5, 0, 0, 0, "illegal15");
    run_instr(0, 0, 0, 0, 0, "hlt");
    run_instr(5, 4, 0, 0, 0, "after_halt");

    // Reset asserted during WB of an ADD: no write strobes that cycle.
    chk("rwb_fetch_pc", 32'(pc_out), 32'(exp_pc));
    instr_in = {5'd4, 11'd3};
    instr_valid_in = 1'b1;
    tick();
    instr_valid_in = 1'b0;
    tick();
    tick();
    reset_in = 1'b1;
    #1;
    chk("rwb_strobes", 32'({acc_wr_out, status_wr_out, data_wr_out}), 32'(0));
    tick();
    reset_in = 1'b0;
    chk("rwb_after_ctl", 32'(obs_ctl()), 32'(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0)));
    chk("rwb_after_pc", 32'(pc_out), 32'(0));
    exp_pc = 11'd0;

    // Random instruction stream.
    for (int i = 0; i < 80; i++) begin
      int op;
      op = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 31));
      run_instr(op, int'($urandom_range(0, 2047)), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), $sformatf("rand%0d_op%0d", i, op));
    end
    chk("final_pc", 32'(pc_out), 32'(exp_pc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
